ctrl_decode_pipe: RTL and testbench

- Decode-stage control unit with an integrated ID/EX control register, load-use hazard detection and a multi-cycle mult/div busy sequencer.
- Sits between the IF/ID register and the EX stage. Decodes the MIPS subset (addu/addiu/subu/slt/slti/sltu/sltiu, lui/and/andi/nor/or/ori/xor/xori, sll/sllv/sra/srav/srl/srlv, beq/bne/j, lw/sw) plus mult/multu/div/divu/mfhi/mflo.
- Drives next-PC selection and pipeline stall/flush.

---
 rtl/ctrl_decode_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: decode-stage control for a MIPS subset pipeline.
// Decodes the ID instruction, owns the ID/EX control register, detects
// load-use and mult/div hazards, and selects the next PC with IF/ID flush.
module ctrl_decode_pipe #(
    parameter int ALU_OP_W = 4,
    parameter int NPC_OP_W = 2,
    parameter int MD_LAT   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instrD,
    input  logic                validD,
    input  logic                isRsRtEq,
    input  logic                exStall,
    output logic [NPC_OP_W-1:0] npcOp,
    output logic                stallF,
    output logic                stallD,
    output logic                flushD,
    output logic                mdBusy,
    output logic                validE,
    output logic                Regfile_weE,
    output logic                DataMem_weE,
    output logic                memToRegE,
    output logic                hiloWeE,
    output logic [ALU_OP_W-1:0] aluOpE,
    output logic                aluSrc1_muxE,
    output logic                aluSrc2_muxE,
    output logic [1:0]          extOpE,
    output logic [1:0]          regSrc_muxE,
    output logic [4:0]          writeRegE
);

    // ALU operation codes, zero-extended to the configured width
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'd1);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4'd2);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4'd3);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4'd4);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'd5);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4'd6);
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(4'd7);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(4'd8);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(4'd9);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(4'd10);
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(4'd11);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [1:0] RSRC_ALU = 2'd0;
    localparam logic [1:0] RSRC_MEM = 2'd1;
    localparam logic [1:0] RSRC_HI  = 2'd2;
    localparam logic [1:0] RSRC_LO  = 2'd3;

    // Counter wide enough to hold MD_LAT; a zero latency keeps it idle at 0
    localparam int CNT_W = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] MD_LAT_C = CNT_W'(MD_LAT);

    logic [5:0] opcode_s;
    logic [5:0] func_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic       unused_shamt_s;

    assign opcode_s       = instrD[31:26];
    assign rs_s           = instrD[25:21];
    assign rt_s           = instrD[20:16];
    assign rd_s           = instrD[15:11];
    assign func_s         = instrD[5:0];
    // The shift amount itself is consumed in EX from the forwarded instruction
    assign unused_shamt_s = ^instrD[10:6];

    logic [ALU_OP_W-1:0] dec_alu_op_s;
    logic                dec_src1_s;
    logic                dec_src2_s;
    logic [1:0]          dec_ext_op_s;
    logic [1:0]          dec_reg_src_s;
    logic                dec_rf_we_s;
    logic                dec_mem_we_s;
    logic                dec_mem_to_reg_s;
    logic                dec_hilo_we_s;
    logic [4:0]          dec_write_reg_s;
    logic                dec_reads_rs_s;
    logic                dec_reads_rt_s;
    logic                dec_is_md_s;
    logic                dec_is_mfhilo_s;
    logic                dec_is_beq_s;
    logic                dec_is_bne_s;
    logic                dec_is_j_s;

    // Instruction decode: control fields and register-read usage for the ID instruction
    always_comb begin
        dec_alu_op_s     = ALU_ADD;
        dec_src1_s       = 1'b0;
        dec_src2_s       = 1'b0;
        dec_ext_op_s     = EXT_ZERO;
        dec_reg_src_s    = RSRC_ALU;
        dec_rf_we_s      = 1'b0;
        dec_mem_we_s     = 1'b0;
        dec_mem_to_reg_s = 1'b0;
        dec_hilo_we_s    = 1'b0;
        dec_write_reg_s  = rt_s;
        dec_reads_rs_s   = 1'b0;
        dec_reads_rt_s   = 1'b0;
        dec_is_md_s      = 1'b0;
        dec_is_mfhilo_s  = 1'b0;
        dec_is_beq_s     = 1'b0;
        dec_is_bne_s     = 1'b0;
        dec_is_j_s       = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_write_reg_s = rd_s;
                dec_reads_rs_s  = 1'b1;
                dec_reads_rt_s  = 1'b1;
                dec_rf_we_s     = 1'b1;
                case (func_s)
                    FN_ADDU: dec_alu_op_s = ALU_ADD;
                    FN_SUBU: dec_alu_op_s = ALU_SUB;
                    FN_SLT:  dec_alu_op_s = ALU_SLT;
                    FN_SLTU: dec_alu_op_s = ALU_SLTU;
                    FN_AND:  dec_alu_op_s = ALU_AND;
                    FN_OR:   dec_alu_op_s = ALU_OR;
                    FN_XOR:  dec_alu_op_s = ALU_XOR;
                    FN_NOR:  dec_alu_op_s = ALU_NOR;
                    FN_SLLV: dec_alu_op_s = ALU_SLL;
                    FN_SRLV: dec_alu_op_s = ALU_SRL;
                    FN_SRAV: dec_alu_op_s = ALU_SRA;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // shamt shifts take their amount from the instruction, not rs
                        dec_src1_s     = 1'b1;
                        dec_reads_rs_s = 1'b0;
                        case (func_s)
                            FN_SLL:  dec_alu_op_s = ALU_SLL;
                            FN_SRL:  dec_alu_op_s = ALU_SRL;
                            default: dec_alu_op_s = ALU_SRA;
                        endcase
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec_reads_rs_s  = 1'b0;
                        dec_reads_rt_s  = 1'b0;
                        dec_is_mfhilo_s = 1'b1;
                        dec_reg_src_s   = (func_s == FN_MFHI) ? RSRC_HI : RSRC_LO;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        dec_rf_we_s   = 1'b0;
                        dec_hilo_we_s = 1'b1;
                        dec_is_md_s   = 1'b1;
                    end
                    default: begin
                        dec_rf_we_s    = 1'b0;
                        dec_reads_rs_s = 1'b0;
                        dec_reads_rt_s = 1'b0;
                    end
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                dec_reads_rs_s = (opcode_s != OP_LUI);
                dec_src2_s     = 1'b1;
                dec_rf_we_s    = 1'b1;
                case (opcode_s)
                    OP_ADDIU: begin dec_alu_op_s = ALU_ADD;  dec_ext_op_s = EXT_SIGN;  end
                    OP_SLTI:  begin dec_alu_op_s = ALU_SLT;  dec_ext_op_s = EXT_SIGN;  end
                    OP_SLTIU: begin dec_alu_op_s = ALU_SLTU; dec_ext_op_s = EXT_SIGN;  end
                    OP_ANDI:  begin dec_alu_op_s = ALU_AND;  dec_ext_op_s = EXT_ZERO;  end
                    OP_ORI:   begin dec_alu_op_s = ALU_OR;   dec_ext_op_s = EXT_ZERO;  end
                    OP_XORI:  begin dec_alu_op_s = ALU_XOR;  dec_ext_op_s = EXT_ZERO;  end
                    OP_LUI:   begin dec_alu_op_s = ALU_LUI;  dec_ext_op_s = EXT_UPPER; end
                    default: begin
                        dec_alu_op_s     = ALU_ADD;
                        dec_ext_op_s     = EXT_SIGN;
                        dec_mem_to_reg_s = 1'b1;
                        dec_reg_src_s    = RSRC_MEM;
                    end
                endcase
            end
            OP_SW: begin
                dec_reads_rs_s = 1'b1;
                dec_reads_rt_s = 1'b1;
                dec_src2_s     = 1'b1;
                dec_ext_op_s   = EXT_SIGN;
                dec_mem_we_s   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_reads_rs_s = 1'b1;
                dec_reads_rt_s = 1'b1;
                dec_alu_op_s   = ALU_SUB;
                dec_ext_op_s   = EXT_SIGN;
                dec_is_beq_s   = (opcode_s == OP_BEQ);
                dec_is_bne_s   = (opcode_s == OP_BNE);
            end
            OP_J: begin
                dec_is_j_s = 1'b1;
            end
            default: begin
                dec_rf_we_s = 1'b0;
            end
        endcase
    end

    logic [CNT_W-1:0] md_cnt_r;
    logic             md_busy_s;
    logic             load_use_s;
    logic             md_haz_s;
    logic             hazard_s;
    logic             stall_s;
    logic             issue_s;
    logic             rf_we_next_s;

    assign md_busy_s  = (md_cnt_r != CNT_W'(0));
    assign load_use_s = validE && memToRegE && (writeRegE != 5'd0) &&
                        ((dec_reads_rs_s && (writeRegE == rs_s)) ||
                         (dec_reads_rt_s && (writeRegE == rt_s)));
    assign md_haz_s   = md_busy_s && (dec_is_md_s || dec_is_mfhilo_s);
    assign hazard_s   = validD && (load_use_s || md_haz_s);
    assign stall_s    = exStall || hazard_s;
    // An instruction actually enters EX only when nothing holds or bubbles the stage
    assign issue_s    = !exStall && !hazard_s && validD;
    assign rf_we_next_s = validD && dec_rf_we_s && (dec_write_reg_s != 5'd0);

    assign stallF = stall_s;
    assign stallD = stall_s;
    assign mdBusy = md_busy_s;

    // Next-PC select and IF/ID flush; no redirect while stalled, idle or in reset
    always_comb begin
        npcOp  = NPC_OP_W'(2'd0);
        flushD = 1'b0;
        if (!rst || stall_s || !validD) begin
            npcOp  = NPC_OP_W'(2'd0);
            flushD = 1'b0;
        end else if (dec_is_j_s) begin
            npcOp  = NPC_OP_W'(2'd2);
            flushD = 1'b1;
        end else if ((dec_is_beq_s && isRsRtEq) || (dec_is_bne_s && !isRsRtEq)) begin
            npcOp  = NPC_OP_W'(2'd1);
            flushD = 1'b1;
        end else begin
            npcOp  = NPC_OP_W'(2'd0);
            flushD = 1'b0;
        end
    end

    // ID/EX control register: hold on exStall, bubble on hazard, else load decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE       <= 1'b0;
            Regfile_weE  <= 1'b0;
            DataMem_weE  <= 1'b0;
            memToRegE    <= 1'b0;
            hiloWeE      <= 1'b0;
            aluOpE       <= ALU_OP_W'(4'd0);
            aluSrc1_muxE <= 1'b0;
            aluSrc2_muxE <= 1'b0;
            extOpE       <= 2'd0;
            regSrc_muxE  <= 2'd0;
            writeRegE    <= 5'd0;
        end else if (exStall) begin
            validE       <= validE;
            Regfile_weE  <= Regfile_weE;
            DataMem_weE  <= DataMem_weE;
            memToRegE    <= memToRegE;
            hiloWeE      <= hiloWeE;
            aluOpE       <= aluOpE;
            aluSrc1_muxE <= aluSrc1_muxE;
            aluSrc2_muxE <= aluSrc2_muxE;
            extOpE       <= extOpE;
            regSrc_muxE  <= regSrc_muxE;
            writeRegE    <= writeRegE;
        end else if (hazard_s) begin
            validE       <= 1'b0;
            Regfile_weE  <= 1'b0;
            DataMem_weE  <= 1'b0;
            memToRegE    <= 1'b0;
            hiloWeE      <= 1'b0;
            aluOpE       <= ALU_OP_W'(4'd0);
            aluSrc1_muxE <= 1'b0;
            aluSrc2_muxE <= 1'b0;
            extOpE       <= 2'd0;
            regSrc_muxE  <= 2'd0;
            writeRegE    <= 5'd0;
        end else begin
            validE       <= validD;
            Regfile_weE  <= rf_we_next_s;
            DataMem_weE  <= validD && dec_mem_we_s;
            memToRegE    <= validD && dec_mem_to_reg_s;
            hiloWeE      <= validD && dec_hilo_we_s;
            aluOpE       <= dec_alu_op_s;
            aluSrc1_muxE <= dec_src1_s;
            aluSrc2_muxE <= dec_src2_s;
            extOpE       <= dec_ext_op_s;
            regSrc_muxE  <= dec_reg_src_s;
            writeRegE    <= dec_write_reg_s;
        end
    end

    // Mult/div occupancy counter: reload on issue, otherwise count down (even when frozen)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt_r <= CNT_W'(0);
        end else if (issue_s && dec_is_md_s) begin
            md_cnt_r <= MD_LAT_C;
        end else if (md_cnt_r != CNT_W'(0)) begin
            md_cnt_r <= md_cnt_r - CNT_W'(1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: table-driven decode vectors plus directed multi-cycle
// sequences for load-use, branch redirect, mult/div busy, exStall and reset.
module tb_ctrl_decode_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic        validD;
    logic        isRsRtEq;
    logic        exStall;
    logic [1:0]  npcOp;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        mdBusy;
    logic        validE;
    logic        Regfile_weE;
    logic        DataMem_weE;
    logic        memToRegE;
    logic        hiloWeE;
    logic [3:0]  aluOpE;
    logic        aluSrc1_muxE;
    logic        aluSrc2_muxE;
    logic [1:0]  extOpE;
    logic [1:0]  regSrc_muxE;
    logic [4:0]  writeRegE;

    int checks = 0;
    int errors = 0;

    ctrl_decode_pipe #(.ALU_OP_W(4), .NPC_OP_W(2), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst), .instrD(instrD), .validD(validD),
        .isRsRtEq(isRsRtEq), .exStall(exStall), .npcOp(npcOp),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .mdBusy(mdBusy),
        .validE(validE), .Regfile_weE(Regfile_weE), .DataMem_weE(DataMem_weE),
        .memToRegE(memToRegE), .hiloWeE(hiloWeE), .aluOpE(aluOpE),
        .aluSrc1_muxE(aluSrc1_muxE), .aluSrc2_muxE(aluSrc2_muxE),
        .extOpE(extOpE), .regSrc_muxE(regSrc_muxE), .writeRegE(writeRegE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // mask bits: which don't-care-able fields a vector constrains
    localparam logic [2:0] M_ALU = 3'b001;
    localparam logic [2:0] M_EXT = 3'b010;
    localparam logic [2:0] M_WR  = 3'b100;

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic        eq;
        logic [2:0]  mask;
        logic [3:0]  alu;
        logic        s1;
        logic        s2;
        logic [1:0]  ext;
        logic [1:0]  rsrc;
        logic [4:0]  wreg;
        logic        rf;
        logic        mem;
        logic        m2r;
        logic        hilo;
        logic        ve;
        logic [1:0]  npc;
        logic        fl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic vld, eq, input logic [2:0] mask,
                                input logic [3:0] alu, input logic s1, s2, input logic [1:0] ext, rsrc,
                                input logic [4:0] wreg, input logic rf, mem, m2r, hilo, ve,
                                input logic [1:0] npc, input logic fl);
        vec_t v;
        v.instr = instr; v.vld = vld; v.eq = eq; v.mask = mask; v.alu = alu;
        v.s1 = s1; v.s2 = s2; v.ext = ext; v.rsrc = rsrc; v.wreg = wreg;
        v.rf = rf; v.mem = mem; v.m2r = m2r; v.hilo = hilo; v.ve = ve;
        v.npc = npc; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld, input logic eq);
        instrD   = ins;
        validD   = vld;
        isRsRtEq = eq;
    endtask

    task automatic do_reset();
        rst = 1'b0; validD = 1'b0; exStall = 1'b0; isRsRtEq = 1'b0; instrD = 32'd0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; instrD = 32'd0; validD = 1'b0; isRsRtEq = 1'b0; exStall = 1'b0;

        //            instr                          vld eq mask        alu s1 s2 ext rs wr  rf mem m2r hl ve npc fl
        vecs.push_back(mk(r_ins(1, 2, 3, 0, 6'h21), 1, 0, M_ALU|M_WR,  0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 4, 0, 6'h23), 1, 0, M_ALU|M_WR,  1, 0, 0, 0, 0, 4,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 5, 0, 6'h2A), 1, 0, M_ALU|M_WR,  2, 0, 0, 0, 0, 5,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 5, 0, 6'h2B), 1, 0, M_ALU|M_WR,  3, 0, 0, 0, 0, 5,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 5, 0, 6'h24), 1, 0, M_ALU|M_WR,  4, 0, 0, 0, 0, 5,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 5, 0, 6'h25), 1, 0, M_ALU|M_WR,  5, 0, 0, 0, 0, 5,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 5, 0, 6'h26), 1, 0, M_ALU|M_WR,  6, 0, 0, 0, 0, 5,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 5, 0, 6'h27), 1, 0, M_ALU|M_WR,  7, 0, 0, 0, 0, 5,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(0, 2, 6, 3, 6'h00), 1, 0, M_ALU|M_WR,  8, 1, 0, 0, 0, 6,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(0, 2, 6, 3, 6'h02), 1, 0, M_ALU|M_WR,  9, 1, 0, 0, 0, 6,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(0, 2, 6, 3, 6'h03), 1, 0, M_ALU|M_WR, 10, 1, 0, 0, 0, 6,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 7, 0, 6'h04), 1, 0, M_ALU|M_WR,  8, 0, 0, 0, 0, 7,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 7, 0, 6'h06), 1, 0, M_ALU|M_WR,  9, 0, 0, 0, 0, 7,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 7, 0, 6'h07), 1, 0, M_ALU|M_WR, 10, 0, 0, 0, 0, 7,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h09, 1, 8, 16'hFFF0), 1, 0, 3'b111,  0, 0, 1, 1, 0, 8,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h09, 1, 0, 16'h0007), 1, 0, 3'b111,  0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h0A, 1, 8, 16'h0005), 1, 0, 3'b111,  2, 0, 1, 1, 0, 8,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h0B, 1, 8, 16'h0005), 1, 0, 3'b111,  3, 0, 1, 1, 0, 8,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h0C, 1, 8, 16'h00FF), 1, 0, 3'b111,  4, 0, 1, 0, 0, 8,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h0D, 1, 8, 16'h00FF), 1, 0, 3'b111,  5, 0, 1, 0, 0, 8,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h0E, 1, 8, 16'h00FF), 1, 0, 3'b111,  6, 0, 1, 0, 0, 8,  1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h0F, 0, 12, 16'h1234), 1, 0, 3'b111, 11, 0, 1, 2, 0, 12, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h23, 1, 9, 16'h0004), 1, 0, 3'b111,  0, 0, 1, 1, 1, 9,  1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h2B, 1, 2, 16'h0008), 1, 0, M_ALU|M_EXT, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h04, 1, 2, 16'h0010), 1, 1, M_EXT,   0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(i_ins(6'h04, 1, 2, 16'h0010), 1, 0, M_EXT,   0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h05, 1, 2, 16'h0010), 1, 0, M_EXT,   0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(i_ins(6'h05, 1, 2, 16'h0010), 1, 1, M_EXT,   0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk({6'h02, 26'h0000040},      1, 0, 3'b000,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2, 1));
        vecs.push_back(mk(r_ins(0, 0, 10, 0, 6'h10), 1, 0, M_WR,      0, 0, 0, 0, 2, 10, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(r_ins(0, 0, 11, 0, 6'h12), 1, 0, M_WR,      0, 0, 0, 0, 3, 11, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk({6'h3F, 26'h0000000},      1, 0, 3'b000,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(i_ins(6'h04, 1, 2, 16'h0010), 0, 1, 3'b000,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 3, 0, 6'h21), 0, 0, 3'b000,      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(r_ins(1, 2, 0, 0, 6'h18), 1, 0, 3'b000,      0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0));

        // reset held with random inputs (first cycle forces a taken jump)
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                drive({6'h02, 26'h0000040}, 1'b1, 1'b0);
                exStall = 1'b0;
            end else begin
                drive($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                exStall = 1'($urandom_range(0, 1));
            end
            #2;
            chk($sformatf("rst_validE%0d", i), {31'd0, validE}, 32'd0);
            chk($sformatf("rst_we%0d", i), {28'd0, Regfile_weE, DataMem_weE, memToRegE, hiloWeE}, 32'd0);
            chk($sformatf("rst_fields%0d", i), {14'd0, aluOpE, aluSrc1_muxE, aluSrc2_muxE, extOpE, regSrc_muxE, writeRegE}, 32'd0);
            chk($sformatf("rst_mdBusy%0d", i), {31'd0, mdBusy}, 32'd0);
            chk($sformatf("rst_npc%0d", i), {29'd0, npcOp, flushD}, 32'd0);
            step();
        end

        // release reset, first addu
        rst = 1'b1; exStall = 1'b0;
        drive(r_ins(1, 2, 3, 0, 6'h21), 1'b1, 1'b0);
        step();
        chk("first_rf_we", {31'd0, Regfile_weE}, 32'd1);
        chk("first_alu", {28'd0, aluOpE}, 32'd0);
        chk("first_wreg", {27'd0, writeRegE}, 32'd3);
        chk("first_rsrc", {30'd0, regSrc_muxE}, 32'd0);

        // decode table
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, vecs[i].vld, vecs[i].eq);
            #2;
            chk($sformatf("v%0d_stallD", i), {31'd0, stallD}, 32'd0);
            chk($sformatf("v%0d_npc", i), {30'd0, npcOp}, {30'd0, vecs[i].npc});
            chk($sformatf("v%0d_flush", i), {31'd0, flushD}, {31'd0, vecs[i].fl});
            step();
            chk($sformatf("v%0d_validE", i), {31'd0, validE}, {31'd0, vecs[i].ve});
            chk($sformatf("v%0d_we", i), {28'd0, Regfile_weE, DataMem_weE, memToRegE, hiloWeE},
                {28'd0, vecs[i].rf, vecs[i].mem, vecs[i].m2r, vecs[i].hilo});
            if ((vecs[i].mask & M_ALU) != 3'd0)
                chk($sformatf("v%0d_alu", i), {26'd0, aluOpE, aluSrc1_muxE, aluSrc2_muxE},
                    {26'd0, vecs[i].alu, vecs[i].s1, vecs[i].s2});
            if ((vecs[i].mask & M_EXT) != 3'd0)
                chk($sformatf("v%0d_ext", i), {30'd0, extOpE}, {30'd0, vecs[i].ext});
            if ((vecs[i].mask & M_WR) != 3'd0)
                chk($sformatf("v%0d_wr", i), {25'd0, regSrc_muxE, writeRegE}, {25'd0, vecs[i].rsrc, vecs[i].wreg});
        end

        // load-use: lw $5 then addu reading $5
        do_reset();
        drive(i_ins(6'h23, 1, 5, 16'h0000), 1'b1, 1'b0);
        step();
        drive(r_ins(5, 2, 6, 0, 6'h21), 1'b1, 1'b0);
        #2;
        chk("lu_stallF", {31'd0, stallF}, 32'd1);
        chk("lu_stallD", {31'd0, stallD}, 32'd1);
        step();
        chk("lu_bubble_validE", {31'd0, validE}, 32'd0);
        chk("lu_bubble_rfwe", {31'd0, Regfile_weE}, 32'd0);
        chk("lu_release_stallD", {31'd0, stallD}, 32'd0);
        step();
        chk("lu_issue", {25'd0, validE, Regfile_weE, writeRegE}, {25'd0, 1'b1, 1'b1, 5'd6});
        // ori does not read rt: no stall
        drive(i_ins(6'h23, 1, 5, 16'h0000), 1'b1, 1'b0);
        step();
        drive(i_ins(6'h0D, 0, 6, 16'h0005), 1'b1, 1'b0);
        #2;
        chk("lu_ori_stallD", {31'd0, stallD}, 32'd0);
        step();
        chk("lu_ori_issue", {24'd0, validE, aluOpE, writeRegE[2:0]}, {24'd0, 1'b1, 4'd5, 3'd6});
        // shamt shift ignores rs field
        drive(i_ins(6'h23, 1, 5, 16'h0000), 1'b1, 1'b0);
        step();
        drive(r_ins(5, 2, 7, 1, 6'h00), 1'b1, 1'b0);
        #2;
        chk("lu_sll_stallD", {31'd0, stallD}, 32'd0);
        step();
        // sw reads rt
        drive(i_ins(6'h23, 1, 5, 16'h0000), 1'b1, 1'b0);
        step();
        drive(i_ins(6'h2B, 1, 5, 16'h0000), 1'b1, 1'b0);
        #2;
        chk("lu_sw_stallD", {31'd0, stallD}, 32'd1);
        step();
        step();
        // lw to $0 never hazards
        drive(i_ins(6'h23, 1, 0, 16'h0000), 1'b1, 1'b0);
        step();
        drive(r_ins(0, 0, 3, 0, 6'h21), 1'b1, 1'b0);
        #2;
        chk("lu_r0_stallD", {31'd0, stallD}, 32'd0);

        // branches suppressed under exStall
        do_reset();
        exStall = 1'b1;
        drive(i_ins(6'h04, 1, 2, 16'h0010), 1'b1, 1'b1);
        #2;
        chk("xs_beq", {28'd0, npcOp, flushD, stallD}, {28'd0, 2'd0, 1'b0, 1'b1});
        drive(i_ins(6'h05, 1, 2, 16'h0010), 1'b1, 1'b0);
        #2;
        chk("xs_bne", {28'd0, npcOp, flushD, stallF}, {28'd0, 2'd0, 1'b0, 1'b1});
        drive({6'h02, 26'h0000040}, 1'b1, 1'b0);
        #2;
        chk("xs_j", {28'd0, npcOp, flushD, stallD}, {28'd0, 2'd0, 1'b0, 1'b1});
        exStall = 1'b0;
        #2;
        chk("xs_j_released", {29'd0, npcOp, flushD}, {29'd0, 2'd2, 1'b1});

        // mult then mflo
        do_reset();
        drive(r_ins(1, 2, 0, 0, 6'h18), 1'b1, 1'b0);
        step();
        drive(r_ins(0, 0, 4, 0, 6'h12), 1'b1, 1'b0);
        chk("md_mult_hilo", {30'd0, validE, hiloWeE}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("md_busy%0d", k), {30'd0, mdBusy, stallD}, 32'd3);
            if (k > 0) chk($sformatf("md_bubble%0d", k), {31'd0, validE}, 32'd0);
            step();
        end
        chk("md_done", {30'd0, mdBusy, stallD}, 32'd0);
        step();
        chk("md_mflo", {24'd0, validE, Regfile_weE, regSrc_muxE, writeRegE[3:0]},
            {24'd0, 1'b1, 1'b1, 2'd3, 4'd4});
        // back-to-back div
        drive(r_ins(1, 2, 0, 0, 6'h18), 1'b1, 1'b0);
        step();
        drive(r_ins(1, 2, 0, 0, 6'h1A), 1'b1, 1'b0);
        #1;
        chk("md_div_stall", {31'd0, stallD}, 32'd1);
        for (int k = 0; k < 4; k++) step();
        chk("md_div_free", {31'd0, stallD}, 32'd0);
        step();
        chk("md_div_issue", {29'd0, validE, hiloWeE, mdBusy}, 32'd7);

        // exStall holds subu while counter runs
        do_reset();
        drive(r_ins(1, 2, 0, 0, 6'h18), 1'b1, 1'b0);
        step();
        drive(r_ins(1, 2, 4, 0, 6'h23), 1'b1, 1'b0);
        step();
        exStall = 1'b1;
        drive(r_ins(1, 2, 3, 0, 6'h21), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("es_stall%0d", k), {30'd0, stallF, stallD}, 32'd3);
            step();
            chk($sformatf("es_hold%0d", k), {21'd0, validE, Regfile_weE, aluOpE, writeRegE},
                {21'd0, 1'b1, 1'b1, 4'd1, 5'd4});
            chk($sformatf("es_mdBusy%0d", k), {31'd0, mdBusy}, (k < 2) ? 32'd1 : 32'd0);
        end
        // asynchronous reset mid-stall
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst", {26'd0, validE, aluOpE, Regfile_weE}, 32'd0);
        rst = 1'b1;
        exStall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
